// File: rtl/xalu_pkg.sv
// xalu_pkg: shared opcode encoding, cycle counts and state type for the
// multiply/divide unit.
package xalu_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    typedef enum logic [3:0] {
        XALU_NONE  = 4'd0,
        XALU_MULT  = 4'd1,
        XALU_MULTU = 4'd2,
        XALU_DIV   = 4'd3,
        XALU_DIVU  = 4'd4,
        XALU_MFHI  = 4'd5,
        XALU_MFLO  = 4'd6,
        XALU_MTHI  = 4'd7,
        XALU_MTLO  = 4'd8
    } xalu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } xalu_state_e;

    function automatic logic is_arith(input xalu_op_e op);
        return (op == XALU_MULT) || (op == XALU_MULTU) ||
               (op == XALU_DIV)  || (op == XALU_DIVU);
    endfunction

    function automatic logic is_mult(input xalu_op_e op);
        return (op == XALU_MULT) || (op == XALU_MULTU);
    endfunction

endpackage

// File: rtl/xalu_calc.sv
// xalu_calc: combinational 64-bit mult/div result ({hi,lo}) and
// divide-by-zero flag.
//   op       in  4   opcode (xalu_op_e encoding)
//   a, b     in  32  rs / rt operands
//   res      out 64  {hi, lo} result of the arithmetic op, 0 otherwise
//   div_zero out 1   div/divu with b == 0
module xalu_calc
    import xalu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_zero
);

    xalu_op_e           w_op;
    logic               w_b_zero;
    logic               w_ovf;
    logic [31:0]        w_div_s_b;
    logic [31:0]        w_div_u_b;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;

    assign w_op     = xalu_op_e'(op);
    assign w_b_zero = (b == 32'd0);
    assign w_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Divisors are forced to 1 for b==0 and for the signed overflow case so
    // the dividers never see an undefined operation. For the overflow case,
    // a/1 gives exactly the wrapped result (q=0x80000000, r=0).
    assign w_div_s_b = (w_b_zero || w_ovf) ? 32'd1 : b;
    assign w_div_u_b = w_b_zero ? 32'd1 : b;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};
    assign w_q_s    = $signed(a) / $signed(w_div_s_b);
    assign w_r_s    = $signed(a) % $signed(w_div_s_b);
    assign w_q_u    = a / w_div_u_b;
    assign w_r_u    = a % w_div_u_b;

    always_comb begin
        res      = 64'd0;
        div_zero = 1'b0;
        case (w_op)
            XALU_MULT:  res = w_prod_s;
            XALU_MULTU: res = w_prod_u;
            XALU_DIV: begin
                res      = {w_r_s, w_q_s};
                div_zero = w_b_zero;
            end
            XALU_DIVU: begin
                res      = {w_r_u, w_q_u};
                div_zero = w_b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/xalu.sv
// xalu: E-stage multiply/divide unit with HI/LO registers.
//   clk    in  1   clock, rising edge
//   reset  in  1   asynchronous active-low reset
//   start  in  1   strobe: E-stage instruction is mult/multu/div/divu
//   op     in  4   opcode (xalu_op_e encoding)
//   a, b   in  32  forwarded rs / rt operands
//   busy   out 1   operation in flight
//   hi, lo out 32  HI / LO registers
//   out    out 32  hi when op is MFHI, otherwise lo
//
// state   | meaning
// ST_IDLE | cnt == 0; accepts start and MTHI/MTLO
// ST_RUN  | cnt != 0; counting down, result parked in pending regs
module xalu
    import xalu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    xalu_op_e    w_op;
    xalu_state_e w_state;
    logic [63:0] w_res;
    logic        w_div_zero;

    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_p_hi, w_p_hi_nxt;
    logic [31:0]      r_p_lo, w_p_lo_nxt;
    logic             r_p_dz, w_p_dz_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;

    assign w_op    = xalu_op_e'(op);
    assign w_state = (r_cnt == '0) ? ST_IDLE : ST_RUN;

    xalu_calc u_calc (
        .op       (op),
        .a        (a),
        .b        (b),
        .res      (w_res),
        .div_zero (w_div_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_p_hi <= '0;
            r_p_lo <= '0;
            r_p_dz <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_p_hi <= w_p_hi_nxt;
            r_p_lo <= w_p_lo_nxt;
            r_p_dz <= w_p_dz_nxt;
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
        end
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_p_hi_nxt = r_p_hi;
        w_p_lo_nxt = r_p_lo;
        w_p_dz_nxt = r_p_dz;
        w_hi_nxt   = r_hi;
        w_lo_nxt   = r_lo;
        case (w_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_arith(w_op)) begin
                        w_p_hi_nxt = w_res[63:32];
                        w_p_lo_nxt = w_res[31:0];
                        w_p_dz_nxt = w_div_zero;
                        w_cnt_nxt  = is_mult(w_op) ? CNT_W'(MULT_CYCLES)
                                                   : CNT_W'(DIV_CYCLES);
                    end
                end else if (w_op == XALU_MTHI) begin
                    w_hi_nxt = a;
                end else if (w_op == XALU_MTLO) begin
                    w_lo_nxt = a;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - 1'b1;
                // Commit on the 1->0 edge; a divide by zero leaves HI/LO alone.
                if (r_cnt == CNT_W'(1) && !r_p_dz) begin
                    w_hi_nxt = r_p_hi;
                    w_lo_nxt = r_p_lo;
                end
            end
            default: ;
        endcase
    end

    assign busy = (w_state == ST_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign out  = (w_op == XALU_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_xalu.sv
module tb_xalu;
    import xalu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi, lo, out;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    xalu dut (
        .clk   (clk),
        .reset (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .out   (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(busy && (start || op == XALU_MTHI || op == XALU_MTLO)))
                else $error("protocol: start/mt* while busy");
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operands.
    task automatic model_op(input logic [3:0] o, input logic [31:0] x,
                            input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        case (o)
            XALU_MULT: begin
                sx = $signed(x); sy = $signed(y);
                p = sx * sy;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            XALU_MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            XALU_DIV: if (y != 0) begin
                sx = $signed(x); sy = $signed(y);
                q = sx / sy; r = sx % sy;
                m_hi = r[31:0]; m_lo = q[31:0];
            end
            XALU_DIVU: if (y != 0) begin
                sx = {32'd0, x}; sy = {32'd0, y};
                q = sx / sy; r = sx % sy;
                m_hi = r[31:0]; m_lo = q[31:0];
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [31:0] x, input logic [31:0] y);
        int n;
        int exp_n;
        logic [31:0] old_hi;
        old_hi = m_hi;
        exp_n = (o == XALU_MULT || o == XALU_MULTU) ? 5 : 10;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = XALU_NONE; a = $urandom; b = $urandom;
        n = 0;
        while (busy && n < 40) begin
            if (n == 0) chk({tag, "_hold_hi"}, hi, old_hi);
            n++;
            @(negedge clk);
        end
        model_op(o, x, y);
        chk({tag, "_cycles"}, n, exp_n);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] v);
        @(negedge clk);
        op = o; a = v;
        @(negedge clk);
        op = XALU_NONE;
        if (o == XALU_MTHI) m_hi = v; else m_lo = v;
        chk("mt_hi", hi, m_hi);
        chk("mt_lo", lo, m_lo);
    endtask

    task automatic rd(input logic [3:0] o);
        @(negedge clk);
        op = o;
        #1;
        chk(o == XALU_MFHI ? "mfhi_out" : "mflo_out", out,
            o == XALU_MFHI ? m_hi : m_lo);
        op = XALU_NONE;
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult", XALU_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_k", hi, 32'hFFFF_FFFF);
        chk("mult_lo_k", lo, 32'hFFFF_FFFA);
        run_op("multu", XALU_MULTU, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hi_k", hi, 32'h0000_0002);
        run_op("div", XALU_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_k", lo, 32'hFFFF_FFFD);
        chk("div_hi_k", hi, 32'hFFFF_FFFF);
        run_op("divu", XALU_DIVU, 32'd7, 32'd2);
        chk("divu_lo_k", lo, 32'd3);
        chk("divu_hi_k", hi, 32'd1);

        mt(XALU_MTHI, 32'h11);
        mt(XALU_MTLO, 32'h22);
        run_op("divz", XALU_DIV, 32'd5, 32'd0);
        chk("divz_hi_k", hi, 32'h11);
        chk("divz_lo_k", lo, 32'h22);

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = XALU_MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = XALU_NONE;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_hi = 0; m_lo = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_busy2", busy, 0);
        chk("midrst_hi2", hi, 0);
        chk("midrst_lo2", lo, 0);

        run_op("ovf", XALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_lo_k", lo, 32'h8000_0000);
        chk("ovf_hi_k", hi, 32'h0);

        mt(XALU_MTLO, 32'hDEAD_BEEF);
        rd(XALU_MFLO);
        rd(XALU_MFHI);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(1, 8));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
            case (ro)
                XALU_MULT, XALU_MULTU, XALU_DIV, XALU_DIVU:
                    run_op("rnd", ro, ra, rb);
                XALU_MTHI, XALU_MTLO: mt(ro, ra);
                default: rd(ro);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, err_cnt);
        $finish;
    end

endmodule
